// File: rtl/wide_arith_sequencer_if.sv
// Request/response bus for wide_arith_sequencer.
//   master: issue side, drives in_valid/op/a/b and out_ready
//   slave : sequencer side, drives in_ready, out_valid, result and n/z/c/v
// Operands and result are 32*WORDS bits wide, least-significant word at bits [31:0].
interface wide_arith_sequencer_if #(
  parameter int unsigned WORDS = 2
);
  localparam int unsigned W = 32 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         n;
  logic         z;
  logic         c;
  logic         v;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, n, z, c, v
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, n, z, c, v
  );
endinterface

// File: rtl/wide_arith_sequencer.sv
// wide_arith_sequencer
//   Multi-word ADD/ADC/SUB/CMP engine. Operands of WORDS x 32 bits are
//   processed one word per cycle, least-significant first, through a single
//   shared 32-bit adder, chaining the carry between words. A persistent NZCV
//   flags register is updated when the top word completes.
// Ports
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : slave side of wide_arith_sequencer_if
//         op 00 ADD, 01 ADC, 10 SUB, 11 CMP (CMP leaves result untouched)

// Shared 32-bit adder: s = x + (op ? ~y : y) + c_in, with rev swapping the
// operands (x,y) = (b,a) for reverse subtract. c_out is bit 32 of the sum.
module add_adcs_subs_rsbs (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  input  logic        rev,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out
);
  logic [31:0] x;
  logic [31:0] y;

  always_comb begin
    x = rev ? b : a;
    y = rev ? a : b;
    {c_out, s} = {1'b0, x} + {1'b0, (op ? ~y : y)} + {32'd0, c_in};
  end
endmodule

module wide_arith_sequencer #(
  parameter int unsigned WORDS = 2
) (
  input logic                  clk,
  input logic                  rst,
  wide_arith_sequencer_if.slave bus
);
  localparam int unsigned W     = 32 * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  state_e           state;
  op_e              op_q;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic [W-1:0]     shadow;
  logic [W-1:0]     result_q;
  logic             carry_q;
  logic             zacc;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             n_q, z_q, c_q, v_q;

  logic [31:0]      sum;
  logic             c_out;
  logic             sub;
  logic             last;
  logic [W-1:0]     merged;
  logic             a31, b31, s31;
  logic             v_next;

  // Operands are shifted right one word per cycle, so the word under
  // work always sits in [31:0]; on the last cycle that is the top word,
  // whose MSBs feed the overflow computation.
  add_adcs_subs_rsbs u_adder (
    .a     (a_sh[31:0]),
    .b     (b_sh[31:0]),
    .op    (sub),
    .rev   (1'b0),
    .c_in  (carry_q),
    .s     (sum),
    .c_out (c_out)
  );

  always_comb begin
    sub    = (op_q == OP_SUB) || (op_q == OP_CMP);
    last   = (idx == IDX_W'(WORDS - 1));
    merged = shadow;
    merged[idx*32 +: 32] = sum;
    a31    = a_sh[31];
    b31    = b_sh[31];
    s31    = sum[31];
    if (sub) begin
      v_next = (a31 & ~b31 & ~s31) | (~a31 & b31 & s31);
    end else begin
      v_next = (a31 & b31 & ~s31) | (~a31 & ~b31 & s31);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_ADD;
      idx         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      shadow      <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zacc        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            op_q       <= op_e'(bus.op);
            idx        <= '0;
            zacc       <= 1'b1;
            in_ready_q <= 1'b0;
            state      <= RUN;
            case (op_e'(bus.op))
              OP_ADD:  carry_q <= 1'b0;
              OP_ADC:  carry_q <= c_q;
              default: carry_q <= 1'b1;
            endcase
          end
        end
        RUN: begin
          shadow  <= merged;
          carry_q <= c_out;
          zacc    <= zacc & (sum == 32'd0);
          a_sh    <= a_sh >> 32;
          b_sh    <= b_sh >> 32;
          if (last) begin
            n_q <= s31;
            z_q <= zacc & (sum == 32'd0);
            c_q <= c_out;
            v_q <= v_next;
            if (op_q != OP_CMP) begin
              result_q <= merged;
            end
            idx         <= '0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.n         = n_q;
  assign bus.z         = z_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
endmodule

// File: tb/tb_wide_arith_sequencer.sv
// Directed bench for wide_arith_sequencer with WORDS=2 (64-bit operands).
module tb_wide_arith_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wide_arith_sequencer_if #(.WORDS(2)) bus ();

  wide_arith_sequencer #(.WORDS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and wait for out_valid; latency counts edges after accept.
  task automatic run_op(input logic [1:0] op_i, input logic [63:0] a_i, input logic [63:0] b_i,
                        output int lat, output logic [63:0] res, output logic [3:0] f);
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_wait: in_ready=%b required 1 within 20 cycles", bus.in_ready);
    end
    bus.op = op_i; bus.a = a_i; bus.b = b_i; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = bus.result;
    f   = {bus.n, bus.z, bus.c, bus.v};
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.result !== 64'h0) begin failures++; $display("FAIL reset_result: got %h required 0", bus.result); end
    checks++; if ({bus.n, bus.z, bus.c, bus.v} !== 4'b0000) begin failures++; $display("FAIL reset_nzcv: got %b required 0000", {bus.n, bus.z, bus.c, bus.v}); end
  endtask

  task automatic test_add_carry();
    int lat; logic [63:0] res; logic [3:0] f;
    run_op(2'b00, 64'h00000000_FFFFFFFF, 64'h1, lat, res, f);
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency: got %0d required 2", lat); end
    checks++; if (res !== 64'h00000001_00000000) begin failures++; $display("FAIL add_result: got %h required 0000000100000000", res); end
    checks++; if (f !== 4'b0000) begin failures++; $display("FAIL add_nzcv: got %b required 0000", f); end
    release_out();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_handshake: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_sub_borrow();
    int lat; logic [63:0] res; logic [3:0] f;
    run_op(2'b10, 64'h0, 64'h1, lat, res, f);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sub_latency: got %0d required 2", lat); end
    checks++; if (res !== 64'hFFFFFFFF_FFFFFFFF) begin failures++; $display("FAIL sub_result: got %h required ffffffffffffffff", res); end
    checks++; if (f !== 4'b1000) begin failures++; $display("FAIL sub_nzcv: got %b required 1000", f); end
    release_out();
  endtask

  task automatic test_cmp();
    int lat; logic [63:0] res; logic [3:0] f;
    run_op(2'b11, 64'h80000000_00000000, 64'h80000000_00000000, lat, res, f);
    checks++; if (lat !== 2) begin failures++; $display("FAIL cmp_latency: got %0d required 2", lat); end
    checks++; if (res !== 64'hFFFFFFFF_FFFFFFFF) begin failures++; $display("FAIL cmp_result_kept: got %h required ffffffffffffffff", res); end
    checks++; if (f !== 4'b0110) begin failures++; $display("FAIL cmp_nzcv: got %b required 0110", f); end
    release_out();
  endtask

  task automatic test_overflow_wrap_adc();
    int lat; logic [63:0] res; logic [3:0] f;
    run_op(2'b00, 64'h7FFFFFFF_FFFFFFFF, 64'h1, lat, res, f);
    checks++; if (res !== 64'h80000000_00000000) begin failures++; $display("FAIL ovf_result: got %h required 8000000000000000", res); end
    checks++; if (f !== 4'b1001) begin failures++; $display("FAIL ovf_nzcv: got %b required 1001", f); end
    release_out();
    run_op(2'b00, 64'hFFFFFFFF_FFFFFFFF, 64'h1, lat, res, f);
    checks++; if (res !== 64'h0) begin failures++; $display("FAIL wrap_result: got %h required 0", res); end
    checks++; if (f !== 4'b0110) begin failures++; $display("FAIL wrap_nzcv: got %b required 0110", f); end
    release_out();
    run_op(2'b01, 64'h0, 64'h0, lat, res, f);
    checks++; if (res !== 64'h00000000_00000001) begin failures++; $display("FAIL adc_result: got %h required 0000000000000001", res); end
    checks++; if (f !== 4'b0000) begin failures++; $display("FAIL adc_nzcv: got %b required 0000", f); end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat; logic [63:0] res; logic [3:0] f;
    run_op(2'b00, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, lat, res, f);
    checks++; if (res !== 64'hFFFFFFFF_FFFFFFFE) begin failures++; $display("FAIL bp_result: got %h required fffffffffffffffe", res); end
    checks++; if (f !== 4'b1010) begin failures++; $display("FAIL bp_nzcv: got %b required 1010", f); end
    bus.op = 2'b10; bus.a = 64'h5; bus.b = 64'h3; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 64'hFFFFFFFF_FFFFFFFE ||
          {bus.n, bus.z, bus.c, bus.v} !== 4'b1010) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b result=%h nzcv=%b required 1/0/fffffffffffffffe/1010",
                 i, bus.out_valid, bus.in_ready, bus.result, {bus.n, bus.z, bus.c, bus.v});
      end
    end
    bus.in_valid = 1'b0;
    release_out();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.result !== 64'hFFFFFFFF_FFFFFFFE) begin failures++; $display("FAIL bp_no_accept: out_valid=%b result=%h required 0/fffffffffffffffe", bus.out_valid, bus.result); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [63:0] res; logic [3:0] f;
    bus.op = 2'b10; bus.a = 64'h0; bus.b = 64'h1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_hs: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid); end
    checks++; if ({bus.n, bus.z, bus.c, bus.v} !== 4'b0000) begin failures++; $display("FAIL midrst_nzcv: got %b required 0000", {bus.n, bus.z, bus.c, bus.v}); end
    checks++; if (bus.result !== 64'h0) begin failures++; $display("FAIL midrst_result: got %h required 0", bus.result); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_spurious[%0d]: out_valid=%b required 0", i, bus.out_valid); end
    end
    // Carry flag was cleared by reset, so ADC 0+0 yields zero.
    run_op(2'b01, 64'h0, 64'h0, lat, res, f);
    checks++; if (lat !== 2) begin failures++; $display("FAIL adc_rst_latency: got %0d required 2", lat); end
    checks++; if (res !== 64'h0) begin failures++; $display("FAIL adc_rst_result: got %h required 0", res); end
    checks++; if (f !== 4'b0100) begin failures++; $display("FAIL adc_rst_nzcv: got %b required 0100", f); end
    release_out();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_cmp();
    test_overflow_wrap_adc();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
